lcd_ctrl: RTL and testbench

Write-only HD44780 character-LCD controller that consumes the processor's LCD output port and produces the physical LCD pin timing. It sits between the pipeline's LSU output-peripheral region and the board LCD header. It runs the mandatory power-up initialisation autonomously, then accepts one command or data byte at a time through a valid/ready handshake and stretches each transfer to the panel's setup, enable-pulse, hold and execution times.

---
 rtl/lcd_pkg.sv | 47 ++++
 rtl/lcd_timer.sv | 38 +++
 rtl/lcd_ctrl.sv | 176 +++++++++++++++++
 tb/tb_lcd_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the HD44780 write-only controller:
//   - FSM state encoding (3-bit constants)
//   - power-up initialisation sequence (function set, display on,
//     clear, entry mode)
//   - helpers: sequence ROM lookup, clear/home detection, integer max
// -----------------------------------------------------------------------------
package lcd_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_PWRUP     = 3'd0;
   localparam state_t ST_INIT_LOAD = 3'd1;
   localparam state_t ST_IDLE      = 3'd2;
   localparam state_t ST_SETUP     = 3'd3;
   localparam state_t ST_EN_HI     = 3'd4;
   localparam state_t ST_HOLD      = 3'd5;
   localparam state_t ST_WAIT      = 3'd6;

   localparam int INIT_LEN = 4;

   localparam logic [7:0] INIT_FUNC_SET  = 8'h38;  // 8-bit bus, 2 lines, 5x8
   localparam logic [7:0] INIT_DISP_ON   = 8'h0C;  // display on, cursor off
   localparam logic [7:0] INIT_CLEAR     = 8'h01;  // clear display
   localparam logic [7:0] INIT_ENTRY_MOD = 8'h06;  // increment, no shift

   function automatic logic [7:0] init_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    return INIT_FUNC_SET;
         2'd1:    return INIT_DISP_ON;
         2'd2:    return INIT_CLEAR;
         default: return INIT_ENTRY_MOD;
      endcase
   endfunction

   // Clear (0x01) and return-home (0x02/0x03) are the slow instructions;
   // both have every bit above bit 1 clear.
   function automatic logic is_clear_home(input logic rs, input logic [7:0] data);
      return !rs && ((data | 8'h03) == 8'h03);
   endfunction

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_timer.sv
// -----------------------------------------------------------------------------
// lcd_timer
// Loadable down-counter used for every timed phase of the LCD controller.
// A phase of N cycles is obtained by loading N-1 on phase entry; done is
// high while the count is zero, and the count parks at zero.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (count <- RST_VAL)
//   load     in   load load_val this cycle
//   load_val in   W  value to load
//   done     out  count is zero
// -----------------------------------------------------------------------------
module lcd_timer #(
   parameter int           W       = 8,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= RST_VAL;
      end else if (load) begin
         cnt_reg <= load_val;
      end else if (cnt_reg != '0) begin
         cnt_reg <= cnt_reg - 1'b1;
      end
   end

   assign done = (cnt_reg == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// -----------------------------------------------------------------------------
// lcd_ctrl
// Write-only HD44780 character-LCD controller. After reset it waits the
// power-up time, writes the four-instruction init sequence, then accepts one
// instruction/data byte per valid/ready handshake and stretches each write to
// setup / enable-pulse / hold / execution times.
// Ports:
//   clk_i        in   system clock
//   rst_ni       in   asynchronous active-low reset
//   lcd_valid_i  in   request valid
//   lcd_rs_i     in   0 = instruction, 1 = data
//   lcd_data_i   in   8  byte to write
//   lcd_ready_o  out  controller can accept a request (IDLE after init)
//   init_done_o  out  power-up sequence complete, sticky until reset
//   lcd_on_o     out  panel power/backlight enable
//   lcd_en_o     out  HD44780 E
//   lcd_rs_o     out  HD44780 RS
//   lcd_rw_o     out  HD44780 R/W, always 0
//   lcd_data_o   out  8  HD44780 DB7..DB0
// -----------------------------------------------------------------------------
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int T_PWRUP = 750000,
   parameter int T_SETUP = 4,
   parameter int T_EN    = 12,
   parameter int T_HOLD  = 2,
   parameter int T_EXEC  = 2000,
   parameter int T_CLEAR = 82000
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       lcd_valid_i,
   input  logic       lcd_rs_i,
   input  logic [7:0] lcd_data_i,
   output logic       lcd_ready_o,
   output logic       init_done_o,
   output logic       lcd_on_o,
   output logic       lcd_en_o,
   output logic       lcd_rs_o,
   output logic       lcd_rw_o,
   output logic [7:0] lcd_data_o
);

   localparam int T_MAX = max_of(max_of(max_of(T_PWRUP, T_CLEAR), max_of(T_SETUP, T_EN)),
                                 max_of(T_HOLD, T_EXEC));
   localparam int TW    = $clog2(T_MAX) + 1;

   localparam logic [TW-1:0] LD_PWRUP = TW'(T_PWRUP - 1);
   localparam logic [TW-1:0] LD_SETUP = TW'(T_SETUP - 1);
   localparam logic [TW-1:0] LD_EN    = TW'(T_EN - 1);
   localparam logic [TW-1:0] LD_HOLD  = TW'(T_HOLD - 1);
   localparam logic [TW-1:0] LD_EXEC  = TW'(T_EXEC - 1);
   localparam logic [TW-1:0] LD_CLEAR = TW'(T_CLEAR - 1);

   state_t      state_reg, state_next;
   logic [1:0]  idx_reg, idx_next;
   logic        done_reg, done_next;
   logic        rs_reg, rs_next;
   logic [7:0]  data_reg, data_next;
   logic        en_reg, ready_reg, on_reg;

   logic          tmr_load, tmr_done;
   logic [TW-1:0] tmr_load_val;

   lcd_timer #(
      .W       (TW),
      .RST_VAL (LD_PWRUP)
   ) u_timer (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .load     (tmr_load),
      .load_val (tmr_load_val),
      .done     (tmr_done)
   );

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      done_next  = done_reg;
      rs_next    = rs_reg;
      data_next  = data_reg;

      case (state_reg)
         ST_PWRUP: begin
            if (tmr_done) state_next = ST_INIT_LOAD;
         end
         ST_IDLE: begin
            if (lcd_valid_i && ready_reg) begin
               rs_next    = lcd_rs_i;
               data_next  = lcd_data_i;
               state_next = ST_SETUP;
            end
         end
         ST_SETUP: begin
            if (tmr_done) state_next = ST_EN_HI;
         end
         ST_EN_HI: begin
            if (tmr_done) state_next = ST_HOLD;
         end
         ST_HOLD: begin
            if (tmr_done) state_next = ST_WAIT;
         end
         ST_WAIT: begin
            if (tmr_done) begin
               if (done_reg) begin
                  state_next = ST_IDLE;
               end else if (idx_reg == 2'(INIT_LEN - 1)) begin
                  done_next  = 1'b1;
                  state_next = ST_IDLE;
               end else begin
                  idx_next   = idx_reg + 2'd1;
                  state_next = ST_INIT_LOAD;
               end
            end
         end
         default: state_next = ST_PWRUP;
      endcase

      // INIT_LOAD is resolved in the same cycle as the transition into it:
      // the ROM byte is latched straight onto the bus and SETUP starts at
      // once, so an init write costs exactly the same cycles as a user write.
      if (state_next == ST_INIT_LOAD) begin
         rs_next    = 1'b0;
         data_next  = init_byte(idx_next);
         state_next = ST_SETUP;
      end
   end

   // Every transition changes state, so a state change is a phase entry.
   assign tmr_load = (state_next != state_reg);

   always_comb begin
      tmr_load_val = '0;
      case (state_next)
         ST_SETUP: tmr_load_val = LD_SETUP;
         ST_EN_HI: tmr_load_val = LD_EN;
         ST_HOLD:  tmr_load_val = LD_HOLD;
         ST_WAIT:  tmr_load_val = is_clear_home(rs_reg, data_reg) ? LD_CLEAR : LD_EXEC;
         default:  tmr_load_val = '0;
      endcase
   end

   // Pin-facing outputs are registered from the next state so E and ready
   // come straight from flops.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= ST_PWRUP;
         idx_reg   <= 2'd0;
         done_reg  <= 1'b0;
         rs_reg    <= 1'b0;
         data_reg  <= 8'h00;
         en_reg    <= 1'b0;
         ready_reg <= 1'b0;
         on_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         done_reg  <= done_next;
         rs_reg    <= rs_next;
         data_reg  <= data_next;
         en_reg    <= (state_next == ST_EN_HI);
         ready_reg <= (state_next == ST_IDLE) && done_next;
         on_reg    <= 1'b1;
      end
   end

   assign lcd_ready_o = ready_reg;
   assign init_done_o = done_reg;
   assign lcd_on_o    = on_reg;
   assign lcd_en_o    = en_reg;
   assign lcd_rs_o    = rs_reg;
   assign lcd_rw_o    = 1'b0;
   assign lcd_data_o  = data_reg;

endmodule

// File: tb/tb_lcd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lcd_ctrl
// Self-checking bench for lcd_ctrl. A cycle-level reference model schedules
// each write as a window [start, start+setup+en+hold+wait) and derives the
// expected pins from that arithmetic every cycle.
// -----------------------------------------------------------------------------
module tb_lcd_ctrl;

   localparam int T_PWRUP = 20;
   localparam int T_SETUP = 2;
   localparam int T_EN    = 3;
   localparam int T_HOLD  = 1;
   localparam int T_EXEC  = 10;
   localparam int T_CLEAR = 40;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       valid = 1'b0;
   logic       rs_in = 1'b0;
   logic [7:0] data_in = 8'h00;
   logic       lcd_ready, init_done, lcd_on, lcd_en, lcd_rs, lcd_rw;
   logic [7:0] lcd_data;

   lcd_ctrl #(
      .T_PWRUP (T_PWRUP), .T_SETUP (T_SETUP), .T_EN (T_EN),
      .T_HOLD  (T_HOLD),  .T_EXEC  (T_EXEC),  .T_CLEAR (T_CLEAR)
   ) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .lcd_valid_i (valid),
      .lcd_rs_i    (rs_in),
      .lcd_data_i  (data_in),
      .lcd_ready_o (lcd_ready),
      .init_done_o (init_done),
      .lcd_on_o    (lcd_on),
      .lcd_en_o    (lcd_en),
      .lcd_rs_o    (lcd_rs),
      .lcd_rw_o    (lcd_rw),
      .lcd_data_o  (lcd_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rs;
      logic [7:0] d;
   } req_t;

   logic [7:0] init_seq [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

   int         tests = 0;
   int         fails = 0;
   int         cyc;          // clock edges since reset release
   int         s_m;          // start edge of current write
   int         free_m;       // edge after which the write is finished
   int         idx_m;
   bit         done_m;
   logic       rs_m;
   logic [7:0] d_m;
   bit         exp_ready, exp_en;
   bit         prev_ready;
   bit         init_seen;
   int         acc_cyc;
   int         exp_gap;
   req_t       q[$];
   int         gaps_q[$];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
      end
   endtask

   function automatic int wait_of(input logic rs, input logic [7:0] d);
      return (rs == 1'b0 && d <= 8'h03) ? T_CLEAR : T_EXEC;
   endfunction

   task automatic model_start(input int s, input logic rs, input logic [7:0] d);
      s_m    = s;
      rs_m   = rs;
      d_m    = d;
      free_m = s + T_SETUP + T_EN + T_HOLD + wait_of(rs, d);
   endtask

   task automatic model_reset();
      cyc        = 0;
      idx_m      = 0;
      done_m     = 1'b0;
      exp_ready  = 1'b0;
      exp_en     = 1'b0;
      prev_ready = 1'b0;
      init_seen  = 1'b0;
      acc_cyc    = -1;
      q.delete();
      valid      = 1'b0;
      model_start(T_PWRUP, 1'b0, init_seq[0]);
   endtask

   // One clock: sample/check after the edge, advance the model, drive inputs.
   task automatic cycle(input bit noise);
      @(negedge clk);
      cyc++;
      if (!done_m && cyc == free_m) begin
         if (idx_m == 3) begin
            done_m = 1'b1;
         end else begin
            idx_m++;
            model_start(cyc, 1'b0, init_seq[idx_m]);
         end
      end
      exp_ready = done_m && (cyc >= free_m);
      exp_en    = (cyc >= s_m + T_SETUP) && (cyc < s_m + T_SETUP + T_EN);

      check_val("en",    lcd_en,    exp_en);
      check_val("ready", lcd_ready, exp_ready);
      check_val("done",  init_done, done_m);
      check_val("rw",    lcd_rw,    1'b0);
      check_val("on",    lcd_on,    1'b1);
      check_val("data",  lcd_data,  (cyc >= s_m) ? d_m : 8'h00);
      check_val("rs",    lcd_rs,    (cyc >= s_m) ? rs_m : 1'b0);

      if (lcd_ready && !prev_ready) begin
         if (!init_seen) begin
            init_seen = 1'b1;
            check_val("init_ready_cycle", cyc, 114);
            $display("[TB] cycle %0d init complete", cyc);
         end else if (acc_cyc >= 0) begin
            check_val("ready_gap", cyc - acc_cyc, exp_gap);
            gaps_q.push_back(cyc - acc_cyc);
            acc_cyc = -1;
         end
      end
      prev_ready = lcd_ready;

      valid = 1'b0;
      if (q.size() > 0) begin
         valid   = 1'b1;
         rs_in   = q[0].rs;
         data_in = q[0].d;
         if (exp_ready) begin
            model_start(cyc + 1, q[0].rs, q[0].d);
            acc_cyc = cyc + 1;
            exp_gap = free_m - (cyc + 1);
            $display("[TB] cycle %0d accept rs=%0d data=%02h expect gap %0d",
                     cyc + 1, q[0].rs, q[0].d, exp_gap);
            void'(q.pop_front());
         end
      end else if (noise && !exp_ready && $urandom_range(0, 3) == 0) begin
         valid   = 1'b1;
         rs_in   = 1'($urandom);
         data_in = 8'($urandom);
      end
   endtask

   task automatic run_until_idle(input int bound);
      int n = 0;
      while (!(q.size() == 0 && exp_ready && acc_cyc < 0) && n < bound) begin
         cycle(1'b0);
         n++;
      end
      check_val("idle_reached", (q.size() == 0 && exp_ready && acc_cyc < 0), 1'b1);
   endtask

   task automatic push_req(input logic rs, input logic [7:0] d);
      req_t r;
      r.rs = rs;
      r.d  = d;
      q.push_back(r);
   endtask

   int gap;
   int n;

   initial begin
      cyc = 0;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_ready", lcd_ready, 1'b0);
      check_val("rst_done",  init_done, 1'b0);
      check_val("rst_on",    lcd_on,    1'b0);
      check_val("rst_en",    lcd_en,    1'b0);
      check_val("rst_rs",    lcd_rs,    1'b0);
      check_val("rst_rw",    lcd_rw,    1'b0);
      check_val("rst_data",  lcd_data,  8'h00);

      // Release and run the power-up sequence with spurious valid pulses.
      rst_n = 1'b1;
      model_reset();
      repeat (120) cycle(1'b1);
      check_val("init_seen", init_seen, 1'b1);

      // Single data write.
      gaps_q.delete();
      push_req(1'b1, 8'h41);
      run_until_idle(200);
      check_val("gap_data_41", (gaps_q.size() > 0) ? gaps_q[0] : -1, 16);

      // Clear then set-DDRAM, valid held across the busy period.
      gaps_q.delete();
      push_req(1'b0, 8'h01);
      push_req(1'b0, 8'h80);
      run_until_idle(300);
      check_val("gap_clear", (gaps_q.size() > 0) ? gaps_q[0] : -1, 46);
      check_val("gap_80",    (gaps_q.size() > 1) ? gaps_q[1] : -1, 16);

      // Data byte 0x01 is not a clear.
      gaps_q.delete();
      push_req(1'b1, 8'h01);
      run_until_idle(200);
      check_val("gap_data_01", (gaps_q.size() > 0) ? gaps_q[0] : -1, 16);

      // Randomized traffic, biased toward the slow instruction codes.
      for (int t = 0; t < 25; t++) begin
         gap = $urandom_range(0, 6);
         repeat (gap) cycle(1'b1);
         push_req(1'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3))
                                                             : 8'($urandom));
         if ($urandom_range(0, 2) == 0) push_req(1'($urandom), 8'($urandom));
         if ($urandom_range(0, 1) == 1) run_until_idle(400);
      end
      run_until_idle(600);

      // Reset while E is high.
      push_req(1'b1, 8'($urandom));
      n = 0;
      while (!exp_en && n < 60) begin
         cycle(1'b0);
         n++;
      end
      check_val("en_before_rst", lcd_en, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check_val("midrst_en",    lcd_en,    1'b0);
      check_val("midrst_on",    lcd_on,    1'b0);
      check_val("midrst_done",  init_done, 1'b0);
      check_val("midrst_ready", lcd_ready, 1'b0);
      check_val("midrst_data",  lcd_data,  8'h00);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      repeat (120) cycle(1'b1);
      check_val("reinit_seen", init_seen, 1'b1);

      gaps_q.delete();
      push_req(1'b0, 8'h02);
      run_until_idle(200);
      check_val("gap_home", (gaps_q.size() > 0) ? gaps_q[0] : -1, 46);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
